// File: rtl/regfile_pkg.sv
// Shared parameters and helpers for the scoreboarded register file.
package regfile_pkg;

    localparam int unsigned DEF_WIDTH    = 32;
    localparam int unsigned DEF_DEPTH    = 32;
    localparam int unsigned MAX_WR_PORTS = 8;

    function automatic int unsigned addr_w(input int unsigned depth);
        return (depth > 1) ? 32'($clog2(depth)) : 32'd1;
    endfunction

    // Highest-indexed matching write port wins when several target one register.
    function automatic logic [2:0] wr_prio(input logic [MAX_WR_PORTS-1:0] hits);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_WR_PORTS; i++) begin
            if (hits[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/regfile_sb_busy_table.sv
// Busy-bit scoreboard: flush beats set, set beats write-back clear.
module regfile_sb_busy_table
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH       = DEF_DEPTH,
    parameter int unsigned WRITE_PORTS = 2,
    localparam int unsigned ADDR_W     = addr_w(DEPTH)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [WRITE_PORTS-1:0]              wr_en,
    input  logic [WRITE_PORTS-1:0][ADDR_W-1:0]  wr_addr,
    input  logic                                set_en,
    input  logic [ADDR_W-1:0]                   set_addr,
    input  logic                                flush,
    output logic [DEPTH-1:0]                    busy,
    output logic [DEPTH-1:0]                    wr_hit_c
);

    logic [DEPTH-1:0] busy_next;

    always_comb begin
        wr_hit_c = '0;
        for (int i = 0; i < WRITE_PORTS; i++) begin
            for (int d = 0; d < DEPTH; d++) begin
                if (wr_en[i] && (wr_addr[i] == ADDR_W'(d))) wr_hit_c[d] = 1'b1;
            end
        end
    end

    always_comb begin
        busy_next = busy & ~wr_hit_c;
        for (int d = 0; d < DEPTH; d++) begin
            if (set_en && (set_addr == ADDR_W'(d))) busy_next[d] = 1'b1;
        end
        if (flush) busy_next = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy <= '0;
        else     busy <= busy_next;
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with busy-bit scoreboard, write-back bypass and flush.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned DEPTH       = DEF_DEPTH,
    parameter int unsigned READ_PORTS  = 2,
    parameter int unsigned WRITE_PORTS = 2,
    parameter bit          ZERO_REG_EN = 1'b1,
    parameter bit          BYPASS_EN   = 1'b1,
    localparam int unsigned ADDR_W     = addr_w(DEPTH)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [READ_PORTS-1:0]               rd_req_valid,
    input  logic [READ_PORTS-1:0][ADDR_W-1:0]   rd_addr,
    output logic [READ_PORTS-1:0]               rd_req_ready,
    output logic [READ_PORTS-1:0]               rd_resp_valid,
    output logic [READ_PORTS-1:0][WIDTH-1:0]    rd_data,
    input  logic                                rsv_valid,
    input  logic [ADDR_W-1:0]                   rsv_addr,
    output logic                                rsv_ready,
    input  logic [WRITE_PORTS-1:0]              wr_valid,
    input  logic [WRITE_PORTS-1:0][ADDR_W-1:0]  wr_addr,
    input  logic [WRITE_PORTS-1:0][WIDTH-1:0]   wr_data,
    input  logic                                flush,
    output logic [DEPTH-1:0]                    busy,
    output logic                                err_unreserved
);

    localparam int unsigned NPAD     = 1 << ADDR_W;
    localparam int unsigned WP_IDX_W = (WRITE_PORTS > 1) ? 32'($clog2(WRITE_PORTS)) : 32'd1;

    logic [WIDTH-1:0]                  mem [DEPTH];
    logic [WRITE_PORTS-1:0]            wr_en;
    logic [DEPTH-1:0]                  wr_hit_c;
    logic [NPAD-1:0]                   busy_pad;
    logic [NPAD-1:0]                   hit_pad;
    logic                              rsv_zero;
    logic                              set_en;
    logic                              unreserved;
    logic [MAX_WR_PORTS-1:0]           match;
    logic [READ_PORTS-1:0]             rd_acc;
    logic [READ_PORTS-1:0][WIDTH-1:0]  rd_next;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < DEPTH;
    endfunction

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return ZERO_REG_EN && (a == '0);
    endfunction

    // Padded views keep every address-indexed lookup in bounds for non-power-of-2 depths.
    assign busy_pad = NPAD'(busy);
    assign hit_pad  = NPAD'(wr_hit_c);

    always_comb begin
        wr_en      = '0;
        unreserved = 1'b0;
        for (int i = 0; i < WRITE_PORTS; i++) begin
            wr_en[i] = wr_valid[i] && in_range(wr_addr[i]) && !is_zero(wr_addr[i]);
            if (wr_en[i] && !busy_pad[wr_addr[i]]) unreserved = 1'b1;
        end
        if (flush) unreserved = 1'b0;
    end

    always_comb begin
        rsv_zero  = is_zero(rsv_addr);
        rsv_ready = 1'b0;
        if (!flush) begin
            if (rsv_zero)                rsv_ready = 1'b1;
            else if (in_range(rsv_addr)) rsv_ready = !busy_pad[rsv_addr] || hit_pad[rsv_addr];
        end
        set_en = rsv_valid && rsv_ready && !rsv_zero;
    end

    // Read acceptance and post-write data selection per port.
    always_comb begin
        rd_req_ready = '1;
        rd_next      = '0;
        match        = '0;
        for (int p = 0; p < READ_PORTS; p++) begin
            match = '0;
            for (int i = 0; i < WRITE_PORTS; i++) begin
                match[i] = wr_en[i] && (wr_addr[i] == rd_addr[p]);
            end
            if (!is_zero(rd_addr[p]) && in_range(rd_addr[p])) begin
                rd_req_ready[p] = !busy_pad[rd_addr[p]] || (BYPASS_EN && (|match));
                rd_next[p]      = (|match) ? wr_data[WP_IDX_W'(wr_prio(match))]
                                           : mem[rd_addr[p]];
            end
        end
        rd_acc = rd_req_valid & rd_req_ready;
    end

    regfile_sb_busy_table #(
        .DEPTH       (DEPTH),
        .WRITE_PORTS (WRITE_PORTS)
    ) u_busy_table (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .set_en   (set_en),
        .set_addr (rsv_addr),
        .flush    (flush),
        .busy     (busy),
        .wr_hit_c (wr_hit_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < DEPTH; d++) mem[d] <= '0;
            rd_resp_valid  <= '0;
            rd_data        <= '0;
            err_unreserved <= 1'b0;
        end else begin
            for (int i = 0; i < WRITE_PORTS; i++) begin
                if (wr_en[i]) mem[wr_addr[i]] <= wr_data[i];
            end
            rd_resp_valid <= rd_acc;
            for (int p = 0; p < READ_PORTS; p++) begin
                if (rd_acc[p]) rd_data[p] <= rd_next[p];
            end
            if (unreserved) err_unreserved <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb.
module tb_regfile_sb;

    logic             clk;
    logic             rst;
    logic [1:0]       rd_req_valid;
    logic [1:0][4:0]  rd_addr;
    logic [1:0]       rd_req_ready;
    logic [1:0]       rd_resp_valid;
    logic [1:0][31:0] rd_data;
    logic             rsv_valid;
    logic [4:0]       rsv_addr;
    logic             rsv_ready;
    logic [1:0]       wr_valid;
    logic [1:0][4:0]  wr_addr;
    logic [1:0][31:0] wr_data;
    logic             flush;
    logic [31:0]      busy;
    logic             err_unreserved;

    int checks = 0;
    int errors = 0;

    regfile_sb dut (
        .clk            (clk),
        .rst            (rst),
        .rd_req_valid   (rd_req_valid),
        .rd_addr        (rd_addr),
        .rd_req_ready   (rd_req_ready),
        .rd_resp_valid  (rd_resp_valid),
        .rd_data        (rd_data),
        .rsv_valid      (rsv_valid),
        .rsv_addr       (rsv_addr),
        .rsv_ready      (rsv_ready),
        .wr_valid       (wr_valid),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .flush          (flush),
        .busy           (busy),
        .err_unreserved (err_unreserved)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        rd_req_valid = '0;
        rd_addr      = '0;
        rsv_valid    = 1'b0;
        rsv_addr     = '0;
        wr_valid     = '0;
        wr_addr      = '0;
        wr_data      = '0;
        flush        = 1'b0;
    endtask

    task automatic step_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        #1;
        checks++; if (busy !== 32'h0) begin errors++; $display("FAIL reset_busy got %h exp %h", busy, 32'h0); end
        checks++; if (rd_resp_valid !== 2'b00) begin errors++; $display("FAIL reset_resp_valid got %b exp 00", rd_resp_valid); end
        checks++; if (err_unreserved !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err_unreserved); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        idle(); rd_req_valid = 2'b11; rd_addr[0] = 5'd5; rd_addr[1] = 5'd0;
        #1;
        checks++; if (rd_req_ready !== 2'b11) begin errors++; $display("FAIL reset_rd_ready got %b exp 11", rd_req_ready); end
        step_edge();
        checks++; if (rd_resp_valid !== 2'b11) begin errors++; $display("FAIL reset_rd_resp got %b exp 11", rd_resp_valid); end
        checks++; if (rd_data[0] !== 32'h0) begin errors++; $display("FAIL reset_rd_r5 got %h exp 0", rd_data[0]); end
        checks++; if (rd_data[1] !== 32'h0) begin errors++; $display("FAIL reset_rd_r0 got %h exp 0", rd_data[1]); end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        idle(); rsv_valid = 1'b1; rsv_addr = 5'd3; rd_req_valid = 2'b01; rd_addr[0] = 5'd3;
        #1;
        checks++; if (rsv_ready !== 1'b1) begin errors++; $display("FAIL byp_rsv_ready got %b exp 1", rsv_ready); end
        checks++; if (rd_req_ready[0] !== 1'b1) begin errors++; $display("FAIL byp_pre_rsv_read got %b exp 1", rd_req_ready[0]); end
        step_edge();
        checks++; if (busy[3] !== 1'b1) begin errors++; $display("FAIL byp_busy3_set got %b exp 1", busy[3]); end
        @(negedge clk);
        idle(); rd_req_valid = 2'b01; rd_addr[0] = 5'd3;
        #1;
        checks++; if (rd_req_ready[0] !== 1'b0) begin errors++; $display("FAIL byp_stall got %b exp 0", rd_req_ready[0]); end
        step_edge();
        checks++; if (rd_resp_valid[0] !== 1'b0) begin errors++; $display("FAIL byp_stall_resp got %b exp 0", rd_resp_valid[0]); end
        @(negedge clk);
        idle(); rd_req_valid = 2'b01; rd_addr[0] = 5'd3;
        wr_valid = 2'b01; wr_addr[0] = 5'd3; wr_data[0] = 32'hDEADBEEF;
        #1;
        checks++; if (rd_req_ready[0] !== 1'b1) begin errors++; $display("FAIL byp_ready got %b exp 1", rd_req_ready[0]); end
        step_edge();
        checks++; if (rd_resp_valid[0] !== 1'b1) begin errors++; $display("FAIL byp_resp got %b exp 1", rd_resp_valid[0]); end
        checks++; if (rd_data[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL byp_data got %h exp deadbeef", rd_data[0]); end
        checks++; if (busy[3] !== 1'b0) begin errors++; $display("FAIL byp_busy3_clr got %b exp 0", busy[3]); end
    endtask

    task automatic test_dual_write();
        @(negedge clk);
        idle(); rsv_valid = 1'b1; rsv_addr = 5'd7;
        @(negedge clk);
        idle(); wr_valid = 2'b11; wr_addr[0] = 5'd7; wr_addr[1] = 5'd7;
        wr_data[0] = 32'h11; wr_data[1] = 32'h22;
        step_edge();
        checks++; if (busy[7] !== 1'b0) begin errors++; $display("FAIL dual_busy7 got %b exp 0", busy[7]); end
        checks++; if (err_unreserved !== 1'b0) begin errors++; $display("FAIL dual_err got %b exp 0", err_unreserved); end
        @(negedge clk);
        idle(); rd_req_valid = 2'b10; rd_addr[1] = 5'd7;
        step_edge();
        checks++; if (rd_data[1] !== 32'h22) begin errors++; $display("FAIL dual_data got %h exp 22", rd_data[1]); end
    endtask

    task automatic test_rsv_during_write();
        @(negedge clk);
        idle(); rsv_valid = 1'b1; rsv_addr = 5'd4;
        @(negedge clk);
        idle(); rsv_valid = 1'b1; rsv_addr = 5'd4;
        wr_valid = 2'b10; wr_addr[1] = 5'd4; wr_data[1] = 32'h44;
        #1;
        checks++; if (rsv_ready !== 1'b1) begin errors++; $display("FAIL rsvwr_ready got %b exp 1", rsv_ready); end
        step_edge();
        checks++; if (busy[4] !== 1'b1) begin errors++; $display("FAIL rsvwr_busy4 got %b exp 1", busy[4]); end
        checks++; if (err_unreserved !== 1'b0) begin errors++; $display("FAIL rsvwr_err got %b exp 0", err_unreserved); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        idle(); rsv_valid = 1'b1; rsv_addr = 5'd8;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            idle(); rsv_valid = 1'b1; rsv_addr = 5'd8;
            wr_valid = 2'b01; wr_addr[0] = 5'd8; wr_data[0] = 32'h80 + 32'(k);
            #1;
            checks++; if (rsv_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b exp 1", k, rsv_ready); end
            step_edge();
            checks++; if (busy[8] !== 1'b1) begin errors++; $display("FAIL b2b_busy[%0d] got %b exp 1", k, busy[8]); end
        end
        @(negedge clk);
        idle(); wr_valid = 2'b01; wr_addr[0] = 5'd8; wr_data[0] = 32'h83;
        step_edge();
        checks++; if (busy[8] !== 1'b0) begin errors++; $display("FAIL b2b_busy_final got %b exp 0", busy[8]); end
        checks++; if (err_unreserved !== 1'b0) begin errors++; $display("FAIL b2b_err got %b exp 0", err_unreserved); end
        @(negedge clk);
        idle(); rsv_valid = 1'b1; rsv_addr = 5'd0;
        wr_valid = 2'b01; wr_addr[0] = 5'd0; wr_data[0] = 32'h99;
        rd_req_valid = 2'b10; rd_addr[1] = 5'd8;
        #1;
        checks++; if (rsv_ready !== 1'b1) begin errors++; $display("FAIL r0_rsv_ready got %b exp 1", rsv_ready); end
        step_edge();
        checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL r0_busy got %b exp 0", busy[0]); end
        checks++; if (err_unreserved !== 1'b0) begin errors++; $display("FAIL r0_err got %b exp 0", err_unreserved); end
        checks++; if (rd_data[1] !== 32'h83) begin errors++; $display("FAIL b2b_data got %h exp 83", rd_data[1]); end
        @(negedge clk);
        idle(); rd_req_valid = 2'b01; rd_addr[0] = 5'd0;
        step_edge();
        checks++; if (rd_data[0] !== 32'h0) begin errors++; $display("FAIL r0_data got %h exp 0", rd_data[0]); end
    endtask

    task automatic test_flush();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            idle(); rsv_valid = 1'b1;
            rsv_addr = (k == 0) ? 5'd1 : (k == 1) ? 5'd2 : 5'd9;
        end
        step_edge();
        checks++; if (busy !== 32'h0000_0216) begin errors++; $display("FAIL flush_pre_busy got %h exp 00000216", busy); end
        @(negedge clk);
        idle(); flush = 1'b1; rsv_valid = 1'b1; rsv_addr = 5'd10;
        wr_valid = 2'b01; wr_addr[0] = 5'd11; wr_data[0] = 32'hB1;
        #1;
        checks++; if (rsv_ready !== 1'b0) begin errors++; $display("FAIL flush_rsv_ready got %b exp 0", rsv_ready); end
        step_edge();
        checks++; if (busy !== 32'h0) begin errors++; $display("FAIL flush_busy got %h exp 0", busy); end
        checks++; if (err_unreserved !== 1'b0) begin errors++; $display("FAIL flush_err got %b exp 0", err_unreserved); end
        @(negedge clk);
        idle(); rd_req_valid = 2'b11; rd_addr[0] = 5'd4; rd_addr[1] = 5'd11;
        #1;
        checks++; if (rd_req_ready !== 2'b11) begin errors++; $display("FAIL flush_rd_ready got %b exp 11", rd_req_ready); end
        step_edge();
        checks++; if (rd_data[0] !== 32'h44) begin errors++; $display("FAIL flush_r4 got %h exp 44", rd_data[0]); end
        checks++; if (rd_data[1] !== 32'hB1) begin errors++; $display("FAIL flush_r11 got %h exp b1", rd_data[1]); end
    endtask

    task automatic test_unreserved();
        @(negedge clk);
        idle(); wr_valid = 2'b10; wr_addr[1] = 5'd6; wr_data[1] = 32'h66;
        step_edge();
        checks++; if (err_unreserved !== 1'b1) begin errors++; $display("FAIL unres_set got %b exp 1", err_unreserved); end
        @(negedge clk);
        idle();
        step_edge();
        checks++; if (err_unreserved !== 1'b1) begin errors++; $display("FAIL unres_sticky got %b exp 1", err_unreserved); end
        @(negedge clk);
        idle(); rd_req_valid = 2'b01; rd_addr[0] = 5'd6;
        step_edge();
        checks++; if (rd_resp_valid[0] !== 1'b1) begin errors++; $display("FAIL unres_resp got %b exp 1", rd_resp_valid[0]); end
        checks++; if (rd_data[0] !== 32'h66) begin errors++; $display("FAIL unres_data got %h exp 66", rd_data[0]); end
        #2 rst = 1'b1;
        #1;
        checks++; if (rd_resp_valid !== 2'b00) begin errors++; $display("FAIL midrst_resp got %b exp 00", rd_resp_valid); end
        checks++; if (rd_data[0] !== 32'h0) begin errors++; $display("FAIL midrst_data got %h exp 0", rd_data[0]); end
        checks++; if (err_unreserved !== 1'b0) begin errors++; $display("FAIL midrst_err got %b exp 0", err_unreserved); end
        @(negedge clk);
        rst = 1'b0;
        idle(); rd_req_valid = 2'b01; rd_addr[0] = 5'd6;
        step_edge();
        checks++; if (rd_data[0] !== 32'h0) begin errors++; $display("FAIL midrst_mem got %h exp 0", rd_data[0]); end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_dual_write();
        test_rsv_during_write();
        test_back_to_back();
        test_flush();
        test_unreserved();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Multi-port, parametrised register file with an integrated busy-bit scoreboard for the parallel-branch RISC-V core. Issue reserves destination registers, write-back commits data and releases reservations, and read ports use a valid/ready handshake that stalls on pending registers unless write-back bypass covers them. A single-cycle flush drops all outstanding reservations on branch squash without disturbing committed data.

## Interface
- WIDTH, 32, bits per register
- DEPTH, 32, number of registers; ADDR_W = $clog2(DEPTH)
- READ_PORTS, 2, independent read ports
- WRITE_PORTS, 2, write-back ports
- ZERO_REG_EN, 1, register 0 hard-wired to zero, never busy
- BYPASS_EN, 1, allow reads of a busy register when the same cycle's write-back targets it
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- rd_req_valid  in  [READ_PORTS]  read request
- rd_addr  in  [READ_PORTS][ADDR_W]  read address
- rd_req_ready  out  [READ_PORTS]  request accepted this cycle (combinational)
- rd_resp_valid  out  [READ_PORTS]  registered response strobe
- rd_data  out  [READ_PORTS][WIDTH]  registered read data
- rsv_valid  in  1  reserve destination register
- rsv_addr  in  ADDR_W  register to reserve
- rsv_ready  out  1  reservation accepted (combinational)
- wr_valid  in  [WRITE_PORTS]  write-back strobe
- wr_addr  in  [WRITE_PORTS][ADDR_W]  write-back address
- wr_data  in  [WRITE_PORTS][WIDTH]  write-back data
- flush  in  1  clear all busy bits
- busy  out  [DEPTH]  current scoreboard state
- err_unreserved  out  1  sticky: write-back to a non-busy register

## Operation
- Write: each wr_valid port with addr != 0 (or ZERO_REG_EN=0) updates mem and clears busy[addr]. Same address on multiple ports: highest port index wins data.
- Write to a non-busy register: data still commits; err_unreserved sets, cleared only by rst.
- Reserve: rsv_ready = !flush && (!busy[rsv_addr] || any wr hit on rsv_addr). On acceptance busy[rsv_addr] is set; set wins over the same cycle's clear. rsv_addr = 0 with ZERO_REG_EN: always ready, busy unchanged.
- Read: rd_req_ready[p] = !busy[addr] || (BYPASS_EN && wr hit on addr). Address 0 with ZERO_REG_EN is always ready, returns 0.
- Accepted read returns the post-write value: if a same-cycle write targets the address, rd_data carries that write's data (highest port) regardless of BYPASS_EN.
- Non-accepted request: rd_resp_valid 0 next cycle, rd_data holds.
- Flush: all busy bits clear next edge; same-cycle reservation refused; same-cycle writes commit data and do not raise err_unreserved.
- Out-of-range addr (DEPTH not a power of 2): write ignored, read returns 0, reserve refused.

## Timing
- Reset: mem all 0, busy 0, rd_resp_valid 0, rd_data 0, err_unreserved 0; applies asynchronously, mid-operation state discarded.
- Read latency 1 cycle: accept at edge N, rd_resp_valid/rd_data valid after edge N, for one cycle.
- Reserve-to-busy: visible after the accepting edge; a read of that register in the same cycle as the reservation sees the pre-reservation state (not yet busy).
- Write-to-read: bypass accepted same cycle; ordinary read in following cycle sees new value.
- Back-to-back reserve/write/reserve on one register sustained every cycle.

## Structure
- Package regfile_pkg: addr-width function, WIDTH/DEPTH defaults, wr-hit priority helper function.
- Sub-module busy_table: DEPTH busy bits, set/clear/flush priority, hit detection; instantiated once.

## Test plan
- Reset, read r5 and r0 -> rd_resp_valid 1 after one cycle, rd_data 0 on both ports.
- Reserve r3, read r3 -> rd_req_ready 0 until wr port0 writes r3=0xDEADBEEF; same-cycle read accepted, returns 0xDEADBEEF.
- Ports 0 and 1 write r7 with 0x11/0x22 same cycle -> read r7 returns 0x22, busy[7]=0.
- Reserve r4 while port1 writes r4 -> rsv_ready 1, busy[4] stays 1, mem[4] updated.
- Reserve r1,r2,r9 then flush with reserve r10 -> busy all 0, rsv_ready 0, r10 not reserved.
- Write r6 unreserved -> err_unreserved 1 stays until rst; assert rst mid-read -> rd_resp_valid 0 immediately.
